// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dds_pkg
//  Purpose  : Shared constants for the DDS frequency-word recovery block:
//             default phase width, error-counter width, FSM state encodings
//             and a saturating-increment helper for the error counter.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package dds_pkg;

  localparam int PHASE_W_DEF = 24;
  localparam int ERR_W       = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dds_delta_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : dds_delta_cmp
//  Purpose  : Combinational phase-delta extraction and candidate comparison.
//             delta = phase - prev (natural modular wrap); match when the
//             modular signed distance between delta and cand is within TOL.
//  Ports    : i_phase  [PHASE_W]  current phase sample
//             i_prev   [PHASE_W]  previous phase sample
//             i_cand   [PHASE_W]  candidate frequency word
//             o_delta  [PHASE_W]  phase increment of this beat
//             o_match  [1]        |signed(delta - cand)| <= TOL
//  Revision : 1.0  initial release
// ============================================================================
module dds_delta_cmp #(
  parameter int PHASE_W = 24,
  parameter int TOL     = 0
) (
  input  logic [PHASE_W-1:0] i_phase,
  input  logic [PHASE_W-1:0] i_prev,
  input  logic [PHASE_W-1:0] i_cand,
  output logic [PHASE_W-1:0] o_delta,
  output logic               o_match
);

  localparam logic [PHASE_W-1:0] c_tol = PHASE_W'(TOL);

  logic [PHASE_W-1:0] w_diff;
  logic [PHASE_W-1:0] w_mag;

  always_comb begin
    o_delta = i_phase - i_prev;
    w_diff  = o_delta - i_cand;
    // Magnitude of the two's-complement difference. The most negative value
    // negates to itself and, read unsigned, is huge, so it never matches.
    w_mag   = w_diff[PHASE_W-1] ? (~w_diff + 1'b1) : w_diff;
    o_match = (w_mag <= c_tol);
  end

endmodule
`default_nettype wire

// File: rtl/dds_fword_recover.sv
`default_nettype none
// ============================================================================
//  Module   : dds_fword_recover
//  Purpose  : AXI-Stream sink for the DDS phase channel. Recovers the active
//             frequency word from successive phase deltas and reports lock.
//  Ports    : sys_clk              in   sole clock
//             rst                  in   synchronous active-high reset
//             s_axis_phase_tvalid  in   phase beat valid
//             s_axis_phase_tdata   in   accumulated phase [PHASE_W]
//             s_axis_phase_tready  out  sink ready (low during reset)
//             fword_out            out  recovered frequency word (held)
//             fword_valid          out  1-cycle pulse on lock acquisition
//             locked               out  lock status
//             lock_lost            out  1-cycle pulse when lock drops
//             err_cnt              out  saturating count of lock losses
//  Revision : 1.0  initial release
// ============================================================================
module dds_fword_recover
  import dds_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int LOCK_CNT = 16,
  parameter int TOL      = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               s_axis_phase_tvalid,
  input  logic [PHASE_W-1:0] s_axis_phase_tdata,
  output logic               s_axis_phase_tready,
  output logic [PHASE_W-1:0] fword_out,
  output logic               fword_valid,
  output logic               locked,
  output logic               lock_lost,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int MC_W = $clog2(LOCK_CNT);
  localparam int IC_W = $clog2(TIMEOUT + 1);
  localparam logic [MC_W-1:0] c_mc_last    = MC_W'(LOCK_CNT - 1);
  localparam logic [IC_W-1:0] c_timeout    = IC_W'(TIMEOUT);
  localparam logic [IC_W-1:0] c_timeout_m1 = IC_W'(TIMEOUT - 1);

  logic [1:0]         state_q,       state_d;
  logic [PHASE_W-1:0] prev_q,        prev_d;
  logic [PHASE_W-1:0] cand_q,        cand_d;
  logic [MC_W-1:0]    match_cnt_q,   match_cnt_d;
  logic [IC_W-1:0]    idle_cnt_q,    idle_cnt_d;
  logic [PHASE_W-1:0] fword_q,       fword_d;
  logic               fword_valid_q, fword_valid_d;
  logic               locked_q,      locked_d;
  logic               lock_lost_q,   lock_lost_d;
  logic [ERR_W-1:0]   err_cnt_q,     err_cnt_d;
  logic               tready_q,      tready_d;

  logic               w_beat;
  logic               w_timeout;
  logic [PHASE_W-1:0] w_delta;
  logic               w_match;

  dds_delta_cmp #(
    .PHASE_W (PHASE_W),
    .TOL     (TOL)
  ) u_delta_cmp (
    .i_phase (s_axis_phase_tdata),
    .i_prev  (prev_q),
    .i_cand  (cand_q),
    .o_delta (w_delta),
    .o_match (w_match)
  );

  assign w_beat = s_axis_phase_tvalid & tready_q;
  // A beat in the cycle the idle count would reach TIMEOUT suppresses it.
  assign w_timeout = !w_beat && (state_q != ST_IDLE) && (idle_cnt_q == c_timeout_m1);

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    cand_d        = cand_q;
    match_cnt_d   = match_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    fword_d       = fword_q;
    fword_valid_d = 1'b0;
    locked_d      = locked_q;
    lock_lost_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    tready_d      = 1'b1;

    // Idle counter saturates at TIMEOUT so a long stay in IDLE cannot wrap.
    if (w_beat) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != c_timeout) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    if (w_beat) begin
      prev_d = s_axis_phase_tdata;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
        end
        ST_PRIME: begin
          cand_d      = w_delta;
          match_cnt_d = '0;
          state_d     = ST_TRACK;
        end
        ST_TRACK: begin
          if (w_match) begin
            if (match_cnt_q == c_mc_last) begin
              fword_d       = cand_q;
              fword_valid_d = 1'b1;
              locked_d      = 1'b1;
              state_d       = ST_LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            cand_d      = w_delta;
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_match) begin
            locked_d    = 1'b0;
            lock_lost_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
            cand_d      = w_delta;
            match_cnt_d = '0;
            state_d     = ST_TRACK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (w_timeout) begin
      // Losing the stream while locked is a lock loss like any other.
      if (state_q == ST_LOCKED) begin
        lock_lost_d = 1'b1;
        err_cnt_d   = sat_inc(err_cnt_q);
      end
      state_d     = ST_IDLE;
      locked_d    = 1'b0;
      match_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prev_q        <= '0;
      cand_q        <= '0;
      match_cnt_q   <= '0;
      idle_cnt_q    <= '0;
      fword_q       <= '0;
      fword_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      err_cnt_q     <= '0;
      tready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      cand_q        <= cand_d;
      match_cnt_q   <= match_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      fword_q       <= fword_d;
      fword_valid_q <= fword_valid_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
      err_cnt_q     <= err_cnt_d;
      tready_q      <= tready_d;
    end
  end

  assign s_axis_phase_tready = tready_q;
  assign fword_out           = fword_q;
  assign fword_valid         = fword_valid_q;
  assign locked              = locked_q;
  assign lock_lost           = lock_lost_q;
  assign err_cnt             = err_cnt_q;

endmodule
`default_nettype wire
